// File: rtl/traffic_light_conflict_monitor_pkg.sv
// Shared types and constants for the traffic light conflict monitor.
// Light codes, phase/fault enums and the four legal head patterns.
package traffic_light_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  typedef enum logic [1:0] {
    PH_LEFT  = 2'd0,
    PH_RIGHT = 2'd1,
    PH_STR   = 2'd2,
    PH_BACK  = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ILLEGAL  = 3'd1,
    FC_SEQUENCE = 3'd2,
    FC_SHORT    = 3'd3,
    FC_LONG     = 3'd4
  } fault_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Pattern layout is {left, right, str, back}
  localparam logic [11:0] PAT_LEFT  = {GREEN, YELLOW, RED, RED};
  localparam logic [11:0] PAT_RIGHT = {RED, GREEN, YELLOW, RED};
  localparam logic [11:0] PAT_STR   = {RED, RED, GREEN, YELLOW};
  localparam logic [11:0] PAT_BACK  = {YELLOW, RED, RED, GREEN};

  // Legal successor phase; BACK wraps to LEFT
  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/traffic_light_conflict_monitor_if.sv
// Signal-head bus plus monitor status outputs.
// master drives the lights, slave is the monitor.
interface traffic_light_conflict_monitor_if #(
  parameter int CNT_W = 5
);

  logic [2:0]       light_left;
  logic [2:0]       light_right;
  logic [2:0]       light_str;
  logic [2:0]       light_back;
  logic [1:0]       phase;
  logic             phase_vld;
  logic             phase_chg;
  logic [CNT_W-1:0] dwell;
  logic             fault;
  logic [2:0]       fault_code;

  modport master (
    output light_left,
    output light_right,
    output light_str,
    output light_back,
    input  phase,
    input  phase_vld,
    input  phase_chg,
    input  dwell,
    input  fault,
    input  fault_code
  );

  modport slave (
    input  light_left,
    input  light_right,
    input  light_str,
    input  light_back,
    output phase,
    output phase_vld,
    output phase_chg,
    output dwell,
    output fault,
    output fault_code
  );

endinterface

// File: rtl/traffic_phase_decoder.sv
// Combinational decode of the 12-bit head pattern into a phase.
// Anything other than the four legal patterns is flagged illegal.
import traffic_light_pkg::*;

module traffic_phase_decoder (
  input  logic [11:0] i_lights,
  output logic        o_legal,
  output logic [1:0]  o_phase
);

  // Match the sampled pattern against the four legal phases
  always_comb begin
    o_legal = 1'b0;
    o_phase = 2'd0;
    unique case (1'b1)
      (i_lights == PAT_LEFT): begin
        o_legal = 1'b1;
        o_phase = PH_LEFT;
      end
      (i_lights == PAT_RIGHT): begin
        o_legal = 1'b1;
        o_phase = PH_RIGHT;
      end
      (i_lights == PAT_STR): begin
        o_legal = 1'b1;
        o_phase = PH_STR;
      end
      (i_lights == PAT_BACK): begin
        o_legal = 1'b1;
        o_phase = PH_BACK;
      end
      default: begin
        o_legal = 1'b0;
        o_phase = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/traffic_light_conflict_monitor.sv
// Phase-order / dwell-time checker with a sticky first-fault latch.
// Define MON_DWELL_CHECK_EN to enable SHORT and LONG dwell faults.
import traffic_light_pkg::*;

module traffic_light_conflict_monitor #(
  parameter int CNT_W     = 5,
  parameter int MIN_DWELL = 4,
  parameter int MAX_DWELL = 12
) (
  input logic clk,
  input logic rst,
  traffic_light_conflict_monitor_if.slave bus
);

  if (MIN_DWELL < 1 || MAX_DWELL < MIN_DWELL ||
      MAX_DWELL >= (2**CNT_W) - 1) begin : g_bad_param
    $error("traffic_light_conflict_monitor: bad dwell params");
  end

  logic [11:0]      w_lights;
  logic             w_legal;
  logic [1:0]       w_dec;
  logic [CNT_W-1:0] w_sat;
  logic             w_same;
  logic             w_adv;
  logic             w_short;
  logic             w_long;

  state_e           r_state;
  logic [1:0]       r_phase;
  logic             r_vld;
  logic             r_chg;
  logic [CNT_W-1:0] r_dwell;
  logic             r_fault;
  fault_e           r_code;

  state_e           w_nstate;
  logic [1:0]       w_nphase;
  logic             w_nvld;
  logic             w_nchg;
  logic [CNT_W-1:0] w_ndwell;
  logic             w_nfault;
  fault_e           w_ncode;

  assign w_lights = {bus.light_left, bus.light_right,
                     bus.light_str, bus.light_back};

  traffic_phase_decoder u_dec (
    .i_lights (w_lights),
    .o_legal  (w_legal),
    .o_phase  (w_dec)
  );

  assign w_sat  = (&r_dwell) ? r_dwell : r_dwell + 1'b1;
  assign w_same = w_legal && (w_dec == r_phase);
  assign w_adv  = w_legal && (w_dec == next_phase(r_phase));

`ifdef MON_DWELL_CHECK_EN
  localparam logic [CNT_W:0]   LP_MAX = (CNT_W+1)'(MAX_DWELL);
  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_DWELL);

  logic r_first;

  // The first tracked phase may be partially observed: exempt it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_first <= 1'b0;
    else if (r_state == ST_INIT && w_legal)
      r_first <= 1'b1;
    else if (r_state == ST_TRACK && w_adv)
      r_first <= 1'b0;
  end

  assign w_short = !r_first && (r_dwell < LP_MIN);
  assign w_long  = ({1'b0, r_dwell} + 1'b1) > LP_MAX;
`else
  assign w_short = 1'b0;
  assign w_long  = 1'b0;
`endif

  // Next-state, tracking and first-fault selection
  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    w_nvld   = r_vld;
    w_nchg   = 1'b0;
    w_ndwell = r_dwell;
    w_nfault = r_fault;
    w_ncode  = r_code;
    unique case (r_state)
      ST_INIT: begin
        if (w_legal) begin
          w_nstate = ST_TRACK;
          w_nphase = w_dec;
          w_nvld   = 1'b1;
          w_ndwell = CNT_W'(1);
        end else begin
          w_nstate = ST_FAULT;
          w_nfault = 1'b1;
          w_ncode  = FC_ILLEGAL;
        end
      end
      ST_TRACK: begin
        if (!w_legal) begin
          w_nstate = ST_FAULT;
          w_nvld   = 1'b0;
          w_nfault = 1'b1;
          w_ncode  = FC_ILLEGAL;
        end else if (w_same) begin
          if (w_long) begin
            w_nstate = ST_FAULT;
            w_nvld   = 1'b0;
            w_nfault = 1'b1;
            w_ncode  = FC_LONG;
          end else begin
            w_ndwell = w_sat;
          end
        end else if (w_adv) begin
          if (w_short) begin
            w_nstate = ST_FAULT;
            w_nvld   = 1'b0;
            w_nfault = 1'b1;
            w_ncode  = FC_SHORT;
          end else begin
            w_nphase = w_dec;
            w_ndwell = CNT_W'(1);
            w_nchg   = 1'b1;
          end
        end else begin
          w_nstate = ST_FAULT;
          w_nvld   = 1'b0;
          w_nfault = 1'b1;
          w_ncode  = FC_SEQUENCE;
        end
      end
      ST_FAULT: begin
        w_nvld = 1'b0;
      end
      default: begin
        w_nstate = ST_INIT;
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_phase <= 2'd0;
      r_vld   <= 1'b0;
      r_chg   <= 1'b0;
      r_dwell <= '0;
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
    end else begin
      r_state <= w_nstate;
      r_phase <= w_nphase;
      r_vld   <= w_nvld;
      r_chg   <= w_nchg;
      r_dwell <= w_ndwell;
      r_fault <= w_nfault;
      r_code  <= w_ncode;
    end
  end

  assign bus.phase      = r_phase;
  assign bus.phase_vld  = r_vld;
  assign bus.phase_chg  = r_chg;
  assign bus.dwell      = r_dwell;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;

endmodule
